// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap sequencer: FSM states,
// instruction encodings, CSR addresses, trap causes and mstatus bit positions.
package trap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_MEPC,
    W_MCAUSE,
    W_MSTATUS,
    W_MRET,
    ASSERT
  } state_t;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL   = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;

endpackage

// File: rtl/trap_seq.sv
// Machine-mode trap sequencer: detects ECALL/EBREAK/interrupt/MRET, holds the
// pipeline, writes mepc/mcause/mstatus one per cycle, then issues a redirect.
module trap_seq #(
  parameter int ADDR_W = 32,
  parameter int INT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              jump_flag_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_flag_rib_i,
  input  logic [INT_W-1:0]  int_flag_i,
  input  logic [ADDR_W-1:0] csr_mtvec_i,
  input  logic [ADDR_W-1:0] csr_mepc_i,
  input  logic [ADDR_W-1:0] csr_mstatus_i,
  output logic              hold_flag_o,
  output logic              csr_we_o,
  output logic [11:0]       csr_waddr_o,
  output logic [ADDR_W-1:0] csr_wdata_o,
  output logic              int_assert_o,
  output logic [ADDR_W-1:0] int_addr_o
);
  import trap_pkg::*;

  state_t            state_reg;
  logic [ADDR_W-1:0] cause_reg;

  logic              is_ecall;
  logic              is_ebreak;
  logic              sync_evt;
  logic              async_evt;
  logic              mret_evt;
  logic              idle_ok;
  logic              trap_accept;
  logic              mret_accept;
  logic [ADDR_W-1:0] cause_sel;
  logic [ADDR_W-1:0] pc_sel;
  logic [ADDR_W-1:0] trap_status;
  logic [ADDR_W-1:0] mret_status;
  logic [ADDR_W-1:0] mtvec_direct;

  always_comb begin
    is_ecall    = (inst_i == INST_ECALL);
    is_ebreak   = (inst_i == INST_EBREAK);
    sync_evt    = is_ecall || is_ebreak;
    async_evt   = (|int_flag_i) && csr_mstatus_i[MIE_BIT] && !sync_evt;
    mret_evt    = (inst_i == INST_MRET) && !sync_evt && !async_evt;
    // Events are level/instruction-held, so refusing them under bus hold just defers them.
    idle_ok     = (state_reg == IDLE) && !hold_flag_rib_i;
    trap_accept = idle_ok && (sync_evt || async_evt);
    mret_accept = idle_ok && mret_evt;

    if (is_ecall)
      cause_sel = ADDR_W'(CAUSE_ECALL);
    else if (is_ebreak)
      cause_sel = ADDR_W'(CAUSE_EBREAK);
    else
      cause_sel = ADDR_W'(CAUSE_EXT_INT);

    // An interrupt taken while ex redirects must return to the redirect target.
    pc_sel = (async_evt && jump_flag_i) ? jump_addr_i : inst_addr_i;

    trap_status           = csr_mstatus_i;
    trap_status[MPIE_BIT] = csr_mstatus_i[MIE_BIT];
    trap_status[MIE_BIT]  = 1'b0;

    mret_status           = csr_mstatus_i;
    mret_status[MIE_BIT]  = csr_mstatus_i[MPIE_BIT];
    mret_status[MPIE_BIT] = 1'b1;

    mtvec_direct = {csr_mtvec_i[ADDR_W-1:2], 2'b00};
  end

  // Freeze the pipeline already in the detection cycle.
  assign hold_flag_o = !rst_i && ((state_reg != IDLE) || trap_accept || mret_accept);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cause_reg    <= '0;
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
    end else begin
      csr_we_o     <= 1'b0;
      csr_waddr_o  <= '0;
      csr_wdata_o  <= '0;
      int_assert_o <= 1'b0;
      int_addr_o   <= '0;
      // Outputs are loaded one edge early so each state presents its own write.
      case (state_reg)
        IDLE: begin
          if (trap_accept) begin
            state_reg   <= W_MEPC;
            cause_reg   <= cause_sel;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MEPC;
            csr_wdata_o <= pc_sel;
          end else if (mret_accept) begin
            state_reg   <= W_MRET;
            csr_we_o    <= 1'b1;
            csr_waddr_o <= CSR_MSTATUS;
            csr_wdata_o <= mret_status;
          end
        end
        W_MEPC: begin
          state_reg   <= W_MCAUSE;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MCAUSE;
          csr_wdata_o <= cause_reg;
        end
        W_MCAUSE: begin
          state_reg   <= W_MSTATUS;
          csr_we_o    <= 1'b1;
          csr_waddr_o <= CSR_MSTATUS;
          csr_wdata_o <= trap_status;
        end
        W_MSTATUS: begin
          state_reg    <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= mtvec_direct;
        end
        W_MRET: begin
          state_reg    <= ASSERT;
          int_assert_o <= 1'b1;
          int_addr_o   <= csr_mepc_i;
        end
        ASSERT: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/trap_seq.md
Name: trap_seq

Overview:
- Machine-mode trap sequencer for the RV32 core. It detects ECALL, EBREAK, MRET and external interrupts.
- While a trap is in progress it requests a pipeline hold from ctrl.
- It performs the required CSR writes (mepc, mcause, mstatus) one per cycle over the CSR write port.
- It then issues a one-cycle redirect (assert + address) that ex/pc_reg use to jump to mtvec or back to mepc.
- It is the requester side of ctrl's hold_flag_clint_i input.

Parameters:
- ADDR_W, 32, instruction/CSR data width
- INT_W, 8, number of external interrupt request lines

Ports:
- clk_i  input  1  core clock
- rst_i  input  1  asynchronous, active-high reset
- inst_i  input  32  instruction in id stage
- inst_addr_i  input  ADDR_W  PC of inst_i
- jump_flag_i  input  1  ex is redirecting this cycle
- jump_addr_i  input  ADDR_W  ex redirect target
- hold_flag_rib_i  input  1  bus hold currently active
- int_flag_i  input  INT_W  level-sensitive external interrupt requests
- csr_mtvec_i  input  ADDR_W  current mtvec
- csr_mepc_i  input  ADDR_W  current mepc
- csr_mstatus_i  input  ADDR_W  current mstatus
- hold_flag_o  output  1  to ctrl (hold_flag_clint_i)
- csr_we_o  output  1  CSR write enable
- csr_waddr_o  output  12  CSR write address
- csr_wdata_o  output  ADDR_W  CSR write data
- int_assert_o  output  1  one-cycle redirect strobe
- int_addr_o  output  ADDR_W  redirect target

Behaviour:
- Reset:
  - Asynchronous reset returns the FSM to IDLE; all outputs go to 0 and all captured registers are cleared.
  - Reset asserted mid-sequence aborts the sequence; no further CSR writes or redirect occur.
- States: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET, ASSERT.
- Event detection in IDLE (evaluated every cycle):
  - Priority 1, sync: inst_i == ECALL (0x00000073) or EBREAK (0x00100073).
  - Priority 2, async: |int_flag_i and mstatus.MIE (bit 3) and no sync event.
  - Priority 3, MRET: inst_i == 0x30200073.
  - No new event is accepted while hold_flag_rib_i = 1; the event stays pending because it is level/instruction-held.
- On an accepted event, capture:
  - cause: ECALL = 11, EBREAK = 3, interrupt = 0x8000000B.
  - return PC:
    - sync: inst_addr_i.
    - async: jump_addr_i if jump_flag_i, else inst_addr_i.
  - Next state: trap goes to W_MEPC; MRET goes to W_MRET.
- hold_flag_o:
  - Combinational; 1 in the cycle an event is accepted and in every non-IDLE state, including ASSERT.
  - 0 otherwise.
  - The pipeline therefore freezes in the detection cycle.
- W_MEPC: csr_we_o = 1, addr 0x341, data = captured PC.
- W_MCAUSE: csr_we_o = 1, addr 0x342, data = captured cause.
- W_MSTATUS: csr_we_o = 1, addr 0x300, data = mstatus with MPIE (bit 7) = old MIE and MIE = 0. The target is set to csr_mtvec_i.
- W_MRET: csr_we_o = 1, addr 0x300, data = mstatus with MIE = MPIE and MPIE = 1. The target is set to csr_mepc_i.
- ASSERT: int_assert_o = 1 and int_addr_o = target for exactly one cycle, then return to IDLE. int_addr_o is 0 when not asserting.
- Latency:
  - Trap: detection to int_assert_o = 4 cycles.
  - MRET: detection to int_assert_o = 2 cycles.
- csr_we_o is 0 in IDLE and ASSERT; at most one CSR write per cycle.
- Events arriving while not in IDLE are ignored. Interrupts cannot re-enter because MIE has already been cleared.
- mtvec is treated as direct mode; the low 2 bits are forced to 0 in int_addr_o.
- An interrupt that deasserts before it is accepted is lost; no latching.

Decomposition:
- Package trap_pkg:
  - State enum.
  - Instruction encodings: ECALL, EBREAK, MRET.
  - CSR addresses: MSTATUS, MEPC, MCAUSE.
  - Cause constants.
  - mstatus bit indices: MIE = 3, MPIE = 7.
- No sub-module: a single FSM plus capture registers.

Test Plan:
- ECALL at PC 0x100, mtvec = 0x200, MIE = 1, in order:
  - writes mepc = 0x100, then mcause = 11, then mstatus with MIE = 0 and MPIE = 1;
  - int_assert_o with addr 0x200 on cycle 4;
  - hold_flag_o high throughout.
- int_flag_i = 0x01, MIE = 1, jump_flag_i = 1, jump_addr_i = 0x80 -> mepc = 0x80, mcause = 0x8000000B, redirect to mtvec.
- int_flag_i = 0x01 with MIE = 0 -> no hold, no CSR write, no redirect.
- MRET with mepc = 0x104, MPIE = 1 -> mstatus write with MIE = 1, then int_assert_o with addr 0x104 two cycles after detection.
- ECALL while hold_flag_rib_i = 1 for 3 cycles -> nothing starts until the hold drops, then the normal 4-cycle sequence runs.
- rst_i asserted in W_MCAUSE -> all outputs 0 immediately, FSM in IDLE, no redirect afterwards.
